// File: rtl/latch_arb_pkg.sv
// Shared definitions for the latch write arbiter: FSM state encoding and
// a constant-evaluable clog2 used to size pointers and counters.
package latch_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_ENABLE = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_ACK    = 3'd4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping past the top requester back to requester 0.
module rr_priority_pick
  import latch_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sharing one level-sensitive latch bank; sequences
// setup / enable / hold timing on registered D and enable lines.
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] Data,
  output logic [N_REQ-1:0]       Grant,
  output logic [N_REQ-1:0]       Ack,
  output logic [WIDTH-1:0]       Latch_D,
  output logic                   Latch_En,
  output logic                   Busy
);

  localparam int PTR_W   = clog2(N_REQ);
  localparam int MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int CNT_W   = clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  if (N_REQ < 2 || N_REQ > 8 || WIDTH < 1 ||
      SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1) begin : g_bad_params
    $error("latch_write_arbiter: parameter out of range");
  end

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] ptr_after_ack;
  logic [PTR_W-1:0] pick_ptr;
  logic [PTR_W-1:0] pick_winner;
  logic             pick_valid;
  logic             start_write;
  logic [CNT_W-1:0] cnt;

  // The ACK exit edge also acts as the IDLE decision, so a pending request
  // chains straight into SETUP and back-to-back writes keep their cadence.
  assign ptr_after_ack = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign pick_ptr      = (state == ST_ACK) ? ptr_after_ack : ptr;
  assign start_write   = pick_valid && (state == ST_IDLE || state == ST_ACK);

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (Req),
    .ptr    (pick_ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      Grant    <= '0;
      Ack      <= '0;
      Latch_D  <= '0;
      Latch_En <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: cnt <= '0;
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state    <= ST_ENABLE;
            cnt      <= '0;
            Latch_En <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ENABLE: begin
          if (cnt == EN_LAST) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            Latch_En <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= ST_ACK;
            cnt   <= '0;
            Ack   <= Grant;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          cnt   <= '0;
          Ack   <= '0;
          Grant <= '0;
          Busy  <= 1'b0;
          ptr   <= ptr_after_ack;
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          Ack      <= '0;
          Grant    <= '0;
          Busy     <= 1'b0;
          Latch_En <= 1'b0;
        end
      endcase

      // Data is captured exactly once, at the edge the winner is chosen.
      if (start_write) begin
        state   <= ST_SETUP;
        cnt     <= '0;
        owner   <= pick_winner;
        Grant   <= N_REQ'(1) << pick_winner;
        Latch_D <= Data[int'(pick_winner)*WIDTH +: WIDTH];
        Busy    <= 1'b1;
      end
    end
  end

endmodule
